// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache in front of memory_controller.
// Define ICACHE_STATS_EN to build the hit/miss counters.
module icache #(
  parameter int XLEN             = 32,
  parameter int ICACHE_IDX_WIDTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            stall,
  input  logic            if_fetch_enable,
  input  logic [XLEN-1:0] if_pc,
  output logic            icache_busy,
  output logic            icache_inst_ready,
  output logic [XLEN-1:0] icache_inst,
  output logic [XLEN-1:0] icache_inst_pc,
  output logic            icache_mem_enable,
  output logic [XLEN-1:0] icache_inst_addr,
  input  logic            mem_inst_ready,
  input  logic [XLEN-1:0] mem_inst,
  input  logic [XLEN-1:0] mem_inst_addr,
  output logic [31:0]     icache_hit_count,
  output logic [31:0]     icache_miss_count
);

  localparam int LINES = 1 << ICACHE_IDX_WIDTH;
  localparam int TW    = XLEN - ICACHE_IDX_WIDTH - 2;

  typedef enum logic [1:0] {
    IDLE,
    RESP,
    WAIT_MEM
  } state_e;

  state_e state_q, state_d;

  logic [LINES-1:0] valid_q;
  logic [TW-1:0]    tag_q  [LINES];
  logic [XLEN-1:0]  data_q [LINES];

  logic [XLEN-1:0] inst_q, inst_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] addr_q, addr_d;

  logic [ICACHE_IDX_WIDTH-1:0] req_idx, fill_idx;
  logic [TW-1:0]               req_tag, fill_tag;
  logic                        hit, accept, fill;

  assign req_idx  = if_pc[ICACHE_IDX_WIDTH+1:2];
  assign req_tag  = if_pc[XLEN-1:ICACHE_IDX_WIDTH+2];
  assign fill_idx = addr_q[ICACHE_IDX_WIDTH+1:2];
  assign fill_tag = addr_q[XLEN-1:ICACHE_IDX_WIDTH+2];

  assign hit    = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign accept = (state_q != WAIT_MEM) && if_fetch_enable
                  && !stall && !flush;
  // A matching reply fills the line even when a flush drops the response.
  assign fill   = (state_q == WAIT_MEM) && mem_inst_ready
                  && (mem_inst_addr == addr_q);

  always_comb begin
    state_d = state_q;
    inst_d  = inst_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    unique case (state_q)
      IDLE, RESP: begin
        state_d = IDLE;
        if (accept) begin
          pc_d = if_pc;
          if (hit) begin
            state_d = RESP;
            inst_d  = data_q[req_idx];
          end else begin
            state_d = WAIT_MEM;
            addr_d  = {if_pc[XLEN-1:2], 2'b00};
          end
        end
      end
      WAIT_MEM: begin
        if (fill) begin
          state_d = RESP;
          inst_d  = mem_inst;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= '0;
      inst_q  <= '0;
      pc_q    <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      inst_q  <= inst_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      if (fill) valid_q[fill_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill && !rst) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= mem_inst;
    end
  end

  assign icache_busy       = (state_q == WAIT_MEM);
  assign icache_mem_enable = (state_q == WAIT_MEM);
  assign icache_inst_ready = (state_q == RESP) && !flush;
  assign icache_inst       = inst_q;
  assign icache_inst_pc    = pc_q;
  assign icache_inst_addr  = addr_q;

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (accept) begin
      if (hit) hit_cnt_q  <= hit_cnt_q + 32'd1;
      else     miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign icache_hit_count  = hit_cnt_q;
  assign icache_miss_count = miss_cnt_q;
`else
  assign icache_hit_count  = '0;
  assign icache_miss_count = '0;
`endif

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: misses, hits, conflicts, flush, stall, reset.
module tb_icache;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        stall;
  logic        fe;
  logic [31:0] pc;
  logic        busy;
  logic        rdy;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        men;
  logic [31:0] maddr;
  logic        mrdy;
  logic [31:0] minst;
  logic [31:0] mraddr;
  logic [31:0] hcnt;
  logic [31:0] mcnt;

  int n_chk;
  int n_fail;

  icache dut (
    .clk               (clk),
    .rst               (rst),
    .flush             (flush),
    .stall             (stall),
    .if_fetch_enable   (fe),
    .if_pc             (pc),
    .icache_busy       (busy),
    .icache_inst_ready (rdy),
    .icache_inst       (inst),
    .icache_inst_pc    (inst_pc),
    .icache_mem_enable (men),
    .icache_inst_addr  (maddr),
    .mem_inst_ready    (mrdy),
    .mem_inst          (minst),
    .mem_inst_addr     (mraddr),
    .icache_hit_count  (hcnt),
    .icache_miss_count (mcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic reply(input logic [31:0] a, input logic [31:0] d);
    mrdy   = 1'b1;
    mraddr = a;
    minst  = d;
    tick();
    mrdy   = 1'b0;
  endtask

  task automatic miss_fill(input logic [31:0] a, input logic [31:0] d);
    fe = 1'b1;
    pc = a;
    tick();
    fe = 1'b0;
    chk("miss_men", {31'd0, men}, 32'd1);
    chk("miss_addr", maddr, a);
    reply(a, d);
    chk("fill_rdy", {31'd0, rdy}, 32'd1);
    chk("fill_inst", inst, d);
    chk("fill_pc", inst_pc, a);
    tick();
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b1;
    flush  = 1'b0;
    stall  = 1'b0;
    fe     = 1'b0;
    pc     = '0;
    mrdy   = 1'b0;
    minst  = '0;
    mraddr = '0;
    tick();
    tick();
    rst = 1'b0;

    chk("rst_rdy", {31'd0, rdy}, 32'd0);
    chk("rst_men", {31'd0, men}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_pc", inst_pc, 32'd0);
    chk("rst_addr", maddr, 32'd0);
    chk("rst_hcnt", hcnt, 32'd0);
    chk("rst_mcnt", mcnt, 32'd0);

    // cold miss with explicit latency checks
    fe = 1'b1;
    pc = 32'h0000_1000;
    tick();
    fe = 1'b0;
    chk("cold_men", {31'd0, men}, 32'd1);
    chk("cold_busy", {31'd0, busy}, 32'd1);
    chk("cold_addr", maddr, 32'h0000_1000);
    chk("cold_rdy0", {31'd0, rdy}, 32'd0);
    tick();
    chk("cold_hold", {31'd0, men}, 32'd1);
    reply(32'h0000_1000, 32'h0000_0013);
    chk("cold_rdy", {31'd0, rdy}, 32'd1);
    chk("cold_inst", inst, 32'h0000_0013);
    chk("cold_ipc", inst_pc, 32'h0000_1000);
    chk("cold_men0", {31'd0, men}, 32'd0);
    tick();
    chk("cold_pulse", {31'd0, rdy}, 32'd0);

    miss_fill(32'h0000_1004, 32'h0010_0093);

    // back-to-back hits
    fe = 1'b1;
    pc = 32'h0000_1000;
    tick();
    chk("b2b_rdy1", {31'd0, rdy}, 32'd1);
    chk("b2b_inst1", inst, 32'h0000_0013);
    chk("b2b_men1", {31'd0, men}, 32'd0);
    pc = 32'h0000_1004;
    tick();
    fe = 1'b0;
    chk("b2b_rdy2", {31'd0, rdy}, 32'd1);
    chk("b2b_inst2", inst, 32'h0010_0093);
    chk("b2b_pc2", inst_pc, 32'h0000_1004);
    chk("b2b_men2", {31'd0, men}, 32'd0);
    tick();
    chk("b2b_end", {31'd0, rdy}, 32'd0);
`ifdef ICACHE_STATS_EN
    chk("hcnt2", hcnt, 32'd2);
    chk("mcnt2", mcnt, 32'd2);
`else
    chk("hcnt_off", hcnt, 32'd0);
    chk("mcnt_off", mcnt, 32'd0);
`endif

    // conflict on index 0: 0x1040 evicts 0x1000
    miss_fill(32'h0000_1040, 32'h0000_AAAA);
    miss_fill(32'h0000_1000, 32'h0000_0013);

    // mismatched reply is ignored
    fe = 1'b1;
    pc = 32'h0000_2000;
    tick();
    fe = 1'b0;
    reply(32'h0000_3000, 32'h0000_BEEF);
    chk("wrong_men", {31'd0, men}, 32'd1);
    chk("wrong_rdy", {31'd0, rdy}, 32'd0);
    chk("wrong_addr", maddr, 32'h0000_2000);
    reply(32'h0000_2000, 32'h0000_0055);
    chk("right_rdy", {31'd0, rdy}, 32'd1);
    chk("right_inst", inst, 32'h0000_0055);
    tick();

    // flush during a miss
    fe = 1'b1;
    pc = 32'h0000_2100;
    tick();
    fe = 1'b0;
    chk("fl_men1", {31'd0, men}, 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_men0", {31'd0, men}, 32'd0);
    chk("fl_busy", {31'd0, busy}, 32'd0);
    reply(32'h0000_2100, 32'h0000_7777);
    chk("fl_late", {31'd0, rdy}, 32'd0);
    tick();
    chk("fl_late2", {31'd0, rdy}, 32'd0);
    miss_fill(32'h0000_2100, 32'h0000_7777);

    // stall blocks acceptance
    stall = 1'b1;
    fe    = 1'b1;
    pc    = 32'h0000_1004;
    tick();
    chk("st_rdy", {31'd0, rdy}, 32'd0);
    chk("st_men", {31'd0, men}, 32'd0);
    tick();
    chk("st_rdy2", {31'd0, rdy}, 32'd0);
    stall = 1'b0;

    // flush with a request drops it
    flush = 1'b1;
    tick();
    flush = 1'b0;
    fe    = 1'b0;
    chk("flfe_rdy", {31'd0, rdy}, 32'd0);
    tick();

    // reset mid-miss
    fe = 1'b1;
    pc = 32'h0000_3000;
    tick();
    fe = 1'b0;
    chk("rm_men", {31'd0, men}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rm_men0", {31'd0, men}, 32'd0);
    chk("rm_busy", {31'd0, busy}, 32'd0);
    chk("rm_rdy", {31'd0, rdy}, 32'd0);
    chk("rm_addr", maddr, 32'd0);
    chk("rm_inst", inst, 32'd0);
    chk("rm_hcnt", hcnt, 32'd0);
    chk("rm_mcnt", mcnt, 32'd0);
    reply(32'h0000_3000, 32'h0000_1234);
    chk("rm_late", {31'd0, rdy}, 32'd0);
    fe = 1'b1;
    pc = 32'h0000_1004;
    tick();
    fe = 1'b0;
    chk("rm_miss", {31'd0, men}, 32'd1);
    chk("rm_maddr", maddr, 32'h0000_1004);
`ifdef ICACHE_STATS_EN
    chk("rm_mcnt1", mcnt, 32'd1);
`else
    chk("rm_mcnt_off", mcnt, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/icache.md
# icache

Direct-mapped instruction cache between the fetch stage and `memory_controller`. Accepts one PC per request from fetch, returns the 32-bit instruction one cycle later on a hit, and on a miss issues a word fetch over the controller's instruction port (`icache_mem_enable`/`icache_inst_addr` → `mem_inst_ready`/`mem_inst`/`mem_inst_addr`). It holds that request until the matching reply arrives, then fills the line and responds. `flush` from the ROB aborts any pending response without losing cached lines.

## Interface
- `ICACHE_IDX_WIDTH`, default 4: index bits; 2^ICACHE_IDX_WIDTH lines of one 32-bit word each.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  mispredict/redirect; aborts the in-flight request.
- `stall`  in  1  blocks acceptance of new fetch requests.
- `if_fetch_enable`  in  1  fetch request valid.
- `if_pc`  in  `XLEN`  fetch address; bits [1:0] ignored.
- `icache_busy`  out  1  high when a new request cannot be accepted.
- `icache_inst_ready`  out  1  one-cycle pulse: `icache_inst` valid.
- `icache_inst`  out  `XLEN`  returned instruction.
- `icache_inst_pc`  out  `XLEN`  PC of the returned instruction.
- `icache_mem_enable`  out  1  miss request to `memory_controller`; level, held until reply.
- `icache_inst_addr`  out  `XLEN`  word-aligned miss address.
- `mem_inst_ready`  in  1  controller reply valid.
- `mem_inst`  in  `XLEN`  reply data.
- `mem_inst_addr`  in  `XLEN`  reply address.
- `icache_hit_count`  out  32  hit counter (see Configuration).
- `icache_miss_count`  out  32  miss counter (see Configuration).

## Operation
- Address split: index = `pc[ICACHE_IDX_WIDTH+1:2]`; tag = `pc[XLEN-1:ICACHE_IDX_WIDTH+2]`. Per line: valid bit, tag, data word.
- State machine: IDLE, RESP, WAIT_MEM.
- IDLE: a request is accepted when `if_fetch_enable && !stall && !flush`.
  - Hit (valid && tag match) → RESP with data latched.
  - Miss → WAIT_MEM. Latch `{pc[XLEN-1:2],2'b00}` into `icache_inst_addr` and raise `icache_mem_enable`.
- RESP: assert `icache_inst_ready` with `icache_inst` and `icache_inst_pc` for exactly one cycle → IDLE. In the same cycle, a new request may be accepted (back-to-back hits at one per cycle, because `icache_busy` is low in RESP).
- WAIT_MEM: `icache_mem_enable` stays high and `icache_inst_addr` stays stable. On `mem_inst_ready && mem_inst_addr == icache_inst_addr`: write the line (valid=1, tag, data), drop `icache_mem_enable`, → RESP with `mem_inst`. A reply with a non-matching address is ignored.
- `icache_busy` = (state == WAIT_MEM).
- Flush, any state: go to IDLE, drop `icache_mem_enable`, suppress any pending `icache_inst_ready`. Valid bits are kept.
- Flush coinciding with a matching reply in WAIT_MEM: the line is still filled (the data is correct for its address); no response is produced.
- Flush and `if_fetch_enable` in the same cycle: the request is dropped.
- Replies arriving in IDLE or RESP: ignored; no fill.
- `stall` does not pause WAIT_MEM or RESP. It only gates acceptance.

## Timing
- Hit latency: request accepted at edge t → `icache_inst_ready` high in cycle t+1.
- Miss latency: `icache_mem_enable` high from cycle t+1 until the reply cycle r. `icache_inst_ready` is high in cycle r+1.
- `icache_mem_enable` never deasserts in WAIT_MEM except on a matching reply, flush, or reset.
- Reset values: all valid bits 0, state IDLE.
  - `icache_inst_ready`, `icache_mem_enable`, `icache_busy` = 0.
  - `icache_inst`, `icache_inst_pc`, `icache_inst_addr` = 0.
  - Both counters = 0.
- Reset mid-miss: the request is abandoned, the next cycle is IDLE, and a late reply is ignored.

## Configuration
- `ICACHE_STATS_EN` defined: `icache_hit_count` and `icache_miss_count` each increment by 1 per accepted hit or miss. They wrap at 2^32, clear on `rst`, and are not cleared by `flush`.
- `ICACHE_STATS_EN` undefined: both ports are tied to 0 and no counter registers are built.

## Test plan
- Reset, fetch `if_pc=0x0000_1000` (cold) → `icache_mem_enable=1`, `icache_inst_addr=0x1000`. Reply `mem_inst=0x0000_0013` at cycle r → `icache_inst_ready` at r+1 with `icache_inst=0x13` and `icache_inst_pc=0x1000`.
- Refetch `0x1000`, then `0x1004` already cached → ready pulses on two consecutive cycles, no `icache_mem_enable`; with `ICACHE_STATS_EN`, `icache_hit_count` +2.
- Conflict: with IDX=4, fetch `0x1000` then `0x1040` (same index, different tag) → second access misses and evicts. Refetch `0x1000` → misses again.
- Miss at `0x2000`, assert `flush` for one cycle before the reply → `icache_mem_enable` drops next cycle. A later reply for `0x2000` produces no `icache_inst_ready`.
- In WAIT_MEM, reply with `mem_inst_addr=0x3000` while waiting on `0x2000` → ignored, `icache_mem_enable` stays high. The correct reply completes normally.
- `stall=1` with `if_fetch_enable=1` in IDLE → no acceptance and no output. Assert `rst` during WAIT_MEM → all outputs 0 and a subsequent hit lookup misses.
